rgb_fade_sequencer: RTL and testbench

Palette-driven colour sequencer that generates the red, green and blue duty-cycle values for the board's three RGB PWM channels. It walks a small writable palette of colour targets, fading each channel linearly toward the current target at a programmable step rate, holding, then advancing with wrap-around. It sits between the control registers and the per-channel PWM generators, replacing fixed phase-offset rainbow behaviour with a programmable schedule.

---
 rtl/rgb_fade_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: walks a writable palette of RGB targets and fades the
// three PWM duty registers toward each target, one LSB per step tick, then
// holds for a fixed number of ticks before advancing with wrap-around.
module rgb_fade_sequencer #(
    parameter int unsigned R          = 8,
    parameter int unsigned N_COLORS   = 4,
    parameter int unsigned STEP_DIV   = 4,
    parameter int unsigned HOLD_STEPS = 2,
    localparam int unsigned AW        = (N_COLORS > 1) ? $clog2(N_COLORS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [3*R-1:0]  wr_data,
    output logic [R-1:0]    duty_r,
    output logic [R-1:0]    duty_g,
    output logic [R-1:0]    duty_b,
    output logic            duty_upd,
    output logic [AW-1:0]   color_idx,
    output logic            seq_wrap,
    output logic            busy
);

    localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    typedef struct packed {
        logic [R-1:0] r;
        logic [R-1:0] g;
        logic [R-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FADE,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    rgb_t          palette [N_COLORS];
    rgb_t          tgt, tgt_nxt;
    logic [TW-1:0] tick_cnt, tick_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic [R-1:0]  duty_r_nxt, duty_g_nxt, duty_b_nxt;
    logic [AW-1:0] color_idx_nxt;
    logic          duty_upd_nxt, seq_wrap_nxt, busy_nxt;
    logic          tick, all_eq;

    // One LSB toward the target; never overshoots and never leaves 0..2^R-1.
    function automatic logic [R-1:0] step_toward(input logic [R-1:0] cur,
                                                 input logic [R-1:0] dst);
        if (cur < dst)      return cur + R'(1);
        else if (cur > dst) return cur - R'(1);
        else                return cur;
    endfunction

    // Palette storage; writes land at the next edge regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_COLORS); i++) palette[i] <= '0;
        end else if (wr_en && (32'(wr_addr) < N_COLORS)) begin
            palette[wr_addr] <= wr_data;
        end
    end

    // State, counters, target and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tgt       <= '0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            duty_r    <= '0;
            duty_g    <= '0;
            duty_b    <= '0;
            color_idx <= '0;
            duty_upd  <= 1'b0;
            seq_wrap  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            tick_cnt  <= tick_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            duty_r    <= duty_r_nxt;
            duty_g    <= duty_g_nxt;
            duty_b    <= duty_b_nxt;
            color_idx <= color_idx_nxt;
            duty_upd  <= duty_upd_nxt;
            seq_wrap  <= seq_wrap_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state, stepping and pulse generation.
    always_comb begin
        state_nxt     = state;
        tgt_nxt       = tgt;
        tick_cnt_nxt  = tick_cnt;
        hold_cnt_nxt  = hold_cnt;
        duty_r_nxt    = duty_r;
        duty_g_nxt    = duty_g;
        duty_b_nxt    = duty_b;
        color_idx_nxt = color_idx;
        duty_upd_nxt  = 1'b0;
        seq_wrap_nxt  = 1'b0;

        tick   = (tick_cnt == TW'(STEP_DIV - 1));
        all_eq = (tgt == {duty_r, duty_g, duty_b});

        case (state)
            IDLE: begin
                tick_cnt_nxt = '0;
                hold_cnt_nxt = '0;
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                tgt_nxt      = palette[color_idx];
                tick_cnt_nxt = '0;
                hold_cnt_nxt = '0;
                state_nxt    = FADE;
            end
            FADE: begin
                if (all_eq) begin
                    // Restart the tick phase so HOLD spans exactly HOLD_STEPS ticks.
                    state_nxt    = HOLD;
                    tick_cnt_nxt = '0;
                    hold_cnt_nxt = '0;
                end else begin
                    tick_cnt_nxt = tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        duty_r_nxt   = step_toward(duty_r, tgt.r);
                        duty_g_nxt   = step_toward(duty_g, tgt.g);
                        duty_b_nxt   = step_toward(duty_b, tgt.b);
                        duty_upd_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                tick_cnt_nxt = tick ? '0 : tick_cnt + TW'(1);
                if (tick) begin
                    if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
                        hold_cnt_nxt = '0;
                        state_nxt    = LOAD;
                        if (color_idx == AW'(N_COLORS - 1)) begin
                            color_idx_nxt = '0;
                            seq_wrap_nxt  = 1'b1;
                        end else begin
                            color_idx_nxt = color_idx + AW'(1);
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + HW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Dropping enable freezes duties and index and parks in IDLE.
        if (!en && (state != IDLE)) begin
            state_nxt     = IDLE;
            tgt_nxt       = tgt;
            tick_cnt_nxt  = '0;
            hold_cnt_nxt  = '0;
            duty_r_nxt    = duty_r;
            duty_g_nxt    = duty_g;
            duty_b_nxt    = duty_b;
            color_idx_nxt = color_idx;
            duty_upd_nxt  = 1'b0;
            seq_wrap_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: a checkpoint table over one long
// palette run plus hand sequences for pause/rewrite and mid-fade reset.
module tb_rgb_fade_sequencer;

    localparam int unsigned R  = 8;
    localparam int unsigned AW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [3*R-1:0] wr_data = '0;
    logic [R-1:0]   duty_r, duty_g, duty_b;
    logic           duty_upd, seq_wrap, busy;
    logic [AW-1:0]  color_idx;

    rgb_fade_sequencer #(
        .R(R), .N_COLORS(4), .STEP_DIV(4), .HOLD_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .duty_upd(duty_upd), .color_idx(color_idx),
        .seq_wrap(seq_wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r, g, b, idx;
        int busy, upd, wrap;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pal(input logic [AW-1:0] a, input int r, input int g, input int b);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {8'(r), 8'(g), 8'(b)};
        cyc_step();
        wr_en   = 1'b0;
    endtask

    function automatic void add(input int c, input int r, input int g, input int b,
                                input int idx, input int bz, input int up, input int wp);
        vec_t v;
        v.c = c; v.r = r; v.g = g; v.b = b; v.idx = idx;
        v.busy = bz; v.upd = up; v.wrap = wp;
        vecs.push_back(v);
    endfunction

    initial begin
        int vp;
        int upd_a, upd_b, upd_c, upd_d, upd_e, wrap_cnt;
        vp = 0; upd_a = 0; upd_b = 0; upd_c = 0; upd_d = 0; upd_e = 0; wrap_cnt = 0;

        // cycle, r, g, b, idx, busy, duty_upd, seq_wrap
        add(  1, 0,0,0, 0, 1,0,0);   // LOAD
        add(  2, 0,0,0, 0, 1,0,0);   // FADE entry
        add(  5, 0,0,0, 0, 1,0,0);
        add(  6, 1,0,1, 0, 1,1,0);   // first step 4 cycles after FADE entry
        add(  7, 1,0,1, 0, 1,0,0);
        add( 10, 2,0,2, 0, 1,1,0);
        add( 14, 3,0,2, 0, 1,1,0);   // old target reached despite rewrite
        add( 22, 3,0,2, 0, 1,0,0);   // still holding
        add( 23, 3,0,2, 1, 1,0,0);   // advance after 8-cycle hold
        add( 25, 3,0,2, 1, 1,0,0);   // zero-distance colour
        add( 33, 3,0,2, 2, 1,0,0);
        add( 38, 4,1,1, 2, 1,1,0);   // mixed up/down steps
        add( 50, 6,4,1, 2, 1,1,0);
        add( 59, 6,4,1, 3, 1,0,0);
        add( 64, 5,3,0, 3, 1,1,0);   // downward toward zero
        add( 84, 0,0,0, 3, 1,1,0);
        add( 92, 0,0,0, 3, 1,0,0);
        add( 93, 0,0,0, 0, 1,0,1);   // wrap 3 -> 0
        add( 94, 0,0,0, 0, 1,0,0);
        add( 98, 1,1,1, 0, 1,1,0);   // rewritten entry 0 applies after wrap
        add(114, 5,5,5, 0, 1,1,0);
        add(128, 4,4,4, 1, 1,1,0);
        add(132, 3,3,3, 1, 1,1,0);
        add(134, 3,3,3, 1, 0,0,0);   // paused: frozen, not busy
        add(139, 3,3,3, 1, 0,0,0);
        add(141, 3,3,3, 1, 1,0,0);   // re-enter LOAD on same index
        add(145, 3,3,3, 1, 1,0,0);
        add(146, 2,4,3, 1, 1,1,0);   // toward rewritten {0,6,3}
        add(150, 1,5,3, 1, 1,1,0);
        add(154, 0,6,3, 1, 1,1,0);
        add(163, 0,6,3, 2, 1,0,0);
        add(168, 1,5,2, 2, 1,1,0);
        add(170, 1,5,2, 2, 1,0,0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset duty_r", 32'(duty_r), 0);
        check("reset duty_g", 32'(duty_g), 0);
        check("reset duty_b", 32'(duty_b), 0);
        check("reset color_idx", 32'(color_idx), 0);
        check("reset busy", 32'(busy), 0);
        check("reset duty_upd", 32'(duty_upd), 0);
        check("reset seq_wrap", 32'(seq_wrap), 0);
        rst = 1'b0;
        cyc_step();

        write_pal(2'd0, 3, 0, 2);
        write_pal(2'd1, 3, 0, 2);
        write_pal(2'd2, 6, 4, 1);
        write_pal(2'd3, 0, 0, 0);
        check("idle busy after writes", 32'(busy), 0);

        en = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            cyc_step();
            if (duty_upd) begin
                if (c <= 23)                  upd_a++;
                else if (c <= 33)             upd_b++;
                else if (c <= 59)             upd_c++;
                else if (c <= 93)             upd_d++;
                else if (c >= 141 && c <= 162) upd_e++;
            end
            if (seq_wrap) wrap_cnt++;
            while (vp < vecs.size() && vecs[vp].c == c) begin
                check($sformatf("c%0d duty_r", c), 32'(duty_r), 32'(vecs[vp].r));
                check($sformatf("c%0d duty_g", c), 32'(duty_g), 32'(vecs[vp].g));
                check($sformatf("c%0d duty_b", c), 32'(duty_b), 32'(vecs[vp].b));
                check($sformatf("c%0d color_idx", c), 32'(color_idx), 32'(vecs[vp].idx));
                check($sformatf("c%0d busy", c), 32'(busy), 32'(vecs[vp].busy));
                check($sformatf("c%0d duty_upd", c), 32'(duty_upd), 32'(vecs[vp].upd));
                check($sformatf("c%0d seq_wrap", c), 32'(seq_wrap), 32'(vecs[vp].wrap));
                vp++;
            end
            // stimulus for the next edge
            if (c == 6) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = {8'd5, 8'd5, 8'd5};
            end else if (c == 137) begin
                wr_en = 1'b1; wr_addr = 2'd1; wr_data = {8'd0, 8'd6, 8'd3};
            end else begin
                wr_en = 1'b0;
            end
            if (c == 133) en = 1'b0;
            if (c == 140) en = 1'b1;
        end
        check("all table rows reached", 32'(vp), 32'(vecs.size()));
        check("duty_upd count colour 0", 32'(upd_a), 3);
        check("duty_upd count zero-distance", 32'(upd_b), 0);
        check("duty_upd count colour 2", 32'(upd_c), 4);
        check("duty_upd count downward", 32'(upd_d), 6);
        check("duty_upd count after resume", 32'(upd_e), 3);
        check("seq_wrap count", 32'(wrap_cnt), 1);

        // Asynchronous reset in the middle of a fade
        #2;
        rst = 1'b1;
        #1;
        check("async rst duty_r", 32'(duty_r), 0);
        check("async rst duty_g", 32'(duty_g), 0);
        check("async rst duty_b", 32'(duty_b), 0);
        check("async rst color_idx", 32'(color_idx), 0);
        check("async rst busy", 32'(busy), 0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cleared palette: every colour is a zero-distance fade
        upd_a = 0; wrap_cnt = 0;
        en = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            cyc_step();
            if (duty_upd) upd_a++;
            if (seq_wrap) wrap_cnt++;
            if (c == 11) check("zero pal idx c11", 32'(color_idx), 1);
            if (c == 21) check("zero pal idx c21", 32'(color_idx), 2);
            if (c == 31) check("zero pal idx c31", 32'(color_idx), 3);
            if (c == 41) check("zero pal idx c41", 32'(color_idx), 0);
        end
        check("zero pal duty_upd count", 32'(upd_a), 0);
        check("zero pal seq_wrap count", 32'(wrap_cnt), 1);
        check("zero pal duties", 32'({duty_r, duty_g, duty_b}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
